// File: rtl/csa_accum_ctrl_if.sv
// Operand/result stream bundle for the carry-save group accumulator.
// The slave side is the accumulator; the master side is the producer/consumer pair.
interface csa_accum_ctrl_if #(
    parameter int W  = 64,
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          busy;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf, busy
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Sums a variable-length operand group through one carry-save stage, then resolves
// the redundant (s, c) pair with a two-cycle split carry-propagate add.
//
// state  | meaning
// IDLE   | waiting for the first operand of a group
// ACC    | folding further operands into (s, c)
// FIN_LO | low-half carry-propagate add
// FIN_HI | high-half add, result registered
// DONE   | result held until consumer takes it
module csa_accum_ctrl #(
    parameter int W       = 64,
    parameter int MAX_OPS = 16,
    parameter int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    csa_accum_ctrl_if.slave       bus
);
    localparam int H = W / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        FIN_LO = 3'd2,
        FIN_HI = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [CW-1:0] cnt;
    logic          carry_lo;
    logic [H-1:0]  lo_r;
    logic          ovf_r;

    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic [CW-1:0] out_count_r;
    logic          out_ovf_r;
    logic          busy_r;

    logic [W-1:0]  csa_sum;
    logic [W-1:0]  csa_carry;
    logic [H-1:0]  hi_sum;
    logic          accept;
    logic          at_limit;

    assign accept = bus.in_valid && in_ready_r;

    always_comb begin
        csa_sum   = s ^ c ^ bus.in_data;
        // Carry out of bit W-1 falls off the shift: arithmetic is mod 2^W.
        csa_carry = ((s & c) | (s & bus.in_data) | (c & bus.in_data)) << 1;
        hi_sum    = s[W-1:H] + c[W-1:H] + {{(H-1){1'b0}}, carry_lo};
        at_limit  = (cnt == CW'(MAX_OPS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s           <= '0;
            c           <= '0;
            cnt         <= '0;
            carry_lo    <= 1'b0;
            lo_r        <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s      <= bus.in_data;
                        c      <= '0;
                        cnt    <= CW'(1);
                        busy_r <= 1'b1;
                        if (bus.in_last || MAX_OPS == 1) begin
                            ovf_r      <= !bus.in_last;
                            in_ready_r <= 1'b0;
                            state      <= FIN_LO;
                        end else begin
                            ovf_r <= 1'b0;
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        s   <= csa_sum;
                        c   <= csa_carry;
                        cnt <= cnt + CW'(1);
                        if (bus.in_last || at_limit) begin
                            ovf_r      <= !bus.in_last;
                            in_ready_r <= 1'b0;
                            state      <= FIN_LO;
                        end
                    end
                end
                FIN_LO: begin
                    {carry_lo, lo_r} <= {1'b0, s[H-1:0]} + {1'b0, c[H-1:0]};
                    state            <= FIN_HI;
                end
                FIN_HI: begin
                    out_data_r  <= {hi_sum, lo_r};
                    out_count_r <= cnt;
                    out_ovf_r   <= ovf_r;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: hand-computed group sums, overflow, backpressure, reset.
module tb_csa_accum_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    csa_accum_ctrl_if #(.W(64), .CW(5)) bus ();

    csa_accum_ctrl #(.W(64), .MAX_OPS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) break;
            step();
        end
        chk(tag, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [63:0] d, input logic [4:0] n,
                                input logic o);
        wait_valid({tag, "_valid"});
        chk({tag, "_data"},  bus.out_data, d);
        chk({tag, "_count"}, 64'(bus.out_count), 64'(n));
        chk({tag, "_ovf"},   64'(bus.out_ovf), 64'(o));
        step();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_out_data", bus.out_data, 64'd0);
        chk("post_rst_count",    64'(bus.out_count), 64'd0);

        // 5 + 7 + 9, latency from the last accept
        send(64'd5, 1'b0);
        chk("acc_busy", 64'(bus.busy), 64'd1);
        send(64'd7, 1'b0);
        send(64'd9, 1'b1);
        chk("lat_t1_valid",    64'(bus.out_valid), 64'd0);
        chk("lat_t1_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("lat_t2_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("lat_t3_valid", 64'(bus.out_valid), 64'd1);
        chk("g579_data",  bus.out_data, 64'd21);
        chk("g579_count", 64'(bus.out_count), 64'd3);
        chk("g579_ovf",   64'(bus.out_ovf), 64'd0);
        step();
        chk("g579_after_valid",    64'(bus.out_valid), 64'd0);
        chk("g579_after_in_ready", 64'(bus.in_ready), 64'd1);
        chk("g579_after_busy",     64'(bus.busy), 64'd0);
        chk("g579_retain_data",    bus.out_data, 64'd21);

        send(64'hDEAD_BEEF, 1'b1);
        check_result("single", 64'hDEAD_BEEF, 5'd1, 1'b0);

        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_result("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 5'd2, 1'b0);

        send(64'h0000_0000_FFFF_FFFF, 1'b0);
        send(64'h0000_0000_0000_0001, 1'b1);
        check_result("half_carry", 64'h0000_0001_0000_0000, 5'd2, 1'b0);

        send(64'h1234_5678_9ABC_DEF0, 1'b0);
        send(64'h0FED_CBA9_8765_4321, 1'b0);
        send(64'h1111_1111_1111_1111, 1'b1);
        check_result("mixed3", 64'h3333_3333_3333_3322, 5'd3, 1'b0);

        for (int i = 0; i < 16; i++) send(64'd1, 1'b0);
        chk("max_in_ready", 64'(bus.in_ready), 64'd0);
        check_result("max16", 64'd16, 5'd16, 1'b1);

        send(64'd3, 1'b0);
        send(64'd4, 1'b1);
        check_result("after_max", 64'd7, 5'd2, 1'b0);

        // Backpressure: hold result, ignore operands offered meanwhile
        bus.out_ready = 1'b0;
        send(64'd10, 1'b0);
        send(64'd20, 1'b1);
        wait_valid("bp_valid");
        bus.in_valid = 1'b1;
        bus.in_data  = 64'd99;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid",    64'(bus.out_valid), 64'd1);
            chk("bp_hold_data",     bus.out_data, 64'd30);
            chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid",    64'(bus.out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_count",            64'(bus.out_count), 64'd2);

        // Reset mid-group discards the partial sum
        send(64'd1, 1'b0);
        send(64'd2, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_busy",  64'(bus.busy), 64'd0);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_idle",     64'(bus.busy), 64'd0);
        send(64'd100, 1'b1);
        check_result("post_midrst", 64'd100, 5'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
